// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Default 640x480@60 timing constants, PMOD bit positions and the helper
// that packs syncs and colour into the VGA PMOD byte.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // PMOD byte: {hsync, b0, g0, r0, vsync, b1, g1, r1}
  localparam int PMOD_HSYNC = 7;
  localparam int PMOD_B0    = 6;
  localparam int PMOD_G0    = 5;
  localparam int PMOD_R0    = 4;
  localparam int PMOD_VSYNC = 3;
  localparam int PMOD_B1    = 2;
  localparam int PMOD_G1    = 1;
  localparam int PMOD_R1    = 0;

  // rgb is {r[1:0], g[1:0], b[1:0]}
  function automatic logic [7:0] pmod_pack(input logic hs, input logic vs,
                                           input logic [5:0] rgb);
    logic [7:0] b;
    b             = '0;
    b[PMOD_HSYNC] = hs;
    b[PMOD_VSYNC] = vs;
    b[PMOD_R1]    = rgb[5];
    b[PMOD_R0]    = rgb[4];
    b[PMOD_G1]    = rgb[3];
    b[PMOD_G0]    = rgb[2];
    b[PMOD_B1]    = rgb[1];
    b[PMOD_B0]    = rgb[0];
    return b;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
// Enable-gated shift register of configurable width and depth; depth 0 is a
// plain wire.
// Ports: clk, sys_rst (sync, active high, loads RST_VAL into every stage),
//        en (shift), d (input word), q (word delayed by DEPTH enabled steps).
module vga_delay_line #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 0,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         sys_rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, sys_rst, en};
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (sys_rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA timing generator with renderer-latency compensation and
// PMOD output register. Everything advances only on pix_ce steps.
// Ports: clk, sys_rst (sync, active high), pix_ce (pixel enable),
//        rgb_in (renderer colour, RGB_LAT steps after its coordinate),
//        haddr/vaddr (current coordinate), display_on (undelayed active area),
//        line_start/frame_start (one-clk strobes), frame_cnt (completed frames),
//        VGA_rgb (registered PMOD byte).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int ADDR_W    = 10,
  parameter int RGB_LAT   = 0,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               pix_ce,
  input  logic [5:0]         rgb_in,
  output logic [ADDR_W-1:0]  haddr,
  output logic [ADDR_W-1:0]  vaddr,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [7:0]         VGA_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(H_TOTAL - 1);
  localparam logic [ADDR_W-1:0] V_LAST = ADDR_W'(V_TOTAL - 1);

  // Compares run one bit wider so a boundary equal to 2^ADDR_W still fits.
  localparam logic [ADDR_W:0] H_ACT_W  = (ADDR_W+1)'(H_ACTIVE);
  localparam logic [ADDR_W:0] V_ACT_W  = (ADDR_W+1)'(V_ACTIVE);
  localparam logic [ADDR_W:0] HS_START = (ADDR_W+1)'(H_ACTIVE + H_FP);
  localparam logic [ADDR_W:0] HS_END   = (ADDR_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ADDR_W:0] VS_START = (ADDR_W+1)'(V_ACTIVE + V_FP);
  localparam logic [ADDR_W:0] VS_END   = (ADDR_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [7:0] VGA_IDLE = pmod_pack(~HSYNC_POL, ~VSYNC_POL, 6'h00);

  logic [ADDR_W:0] h_w, v_w;
  logic            hsync, vsync;
  logic            hs_d, vs_d, de_d;
  logic [5:0]      colour;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      haddr     <= '0;
      vaddr     <= '0;
      frame_cnt <= '0;
    end else if (pix_ce) begin
      if (haddr == H_LAST) begin
        haddr <= '0;
        if (vaddr == V_LAST) begin
          vaddr     <= '0;
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end else begin
          vaddr <= vaddr + ADDR_W'(1);
        end
      end else begin
        haddr <= haddr + ADDR_W'(1);
      end
    end
  end

  assign h_w = {1'b0, haddr};
  assign v_w = {1'b0, vaddr};

  assign display_on  = (h_w < H_ACT_W) && (v_w < V_ACT_W);
  assign hsync       = ((h_w >= HS_START) && (h_w < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = ((v_w >= VS_START) && (v_w < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  assign line_start  = pix_ce && (haddr == '0);
  assign frame_start = pix_ce && (haddr == '0) && (vaddr == '0);

  // Resets to inactive syncs and blanked display so nothing stale leaks out
  // while the renderer pipeline refills.
  vga_delay_line #(
    .W       (3),
    .DEPTH   (RGB_LAT),
    .RST_VAL ({~HSYNC_POL, ~VSYNC_POL, 1'b0})
  ) u_sync_dly (
    .clk     (clk),
    .sys_rst (sys_rst),
    .en      (pix_ce),
    .d       ({hsync, vsync, display_on}),
    .q       ({hs_d, vs_d, de_d})
  );

  assign colour = de_d ? rgb_in : 6'h00;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      VGA_rgb <= VGA_IDLE;
    end else if (pix_ce) begin
      VGA_rgb <= pmod_pack(hs_d, vs_d, colour);
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and PMOD output stage: the next generation of the fixed 640x480 timing block used by the game top. Produces pixel coordinates, blanking, programmable-polarity syncs, line/frame strobes and a frame counter, all advancing on a pixel clock enable. Delays sync and blanking to match a renderer of configurable latency, then packs the result into the 8-bit VGA PMOD byte. Sits between the system clock/reset and the game renderer; the renderer consumes `haddr`/`vaddr` and returns `rgb_in`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- `HSYNC_POL` / `VSYNC_POL`, 0 / 0, sync active level (0 = active-low)
- `ADDR_W`, 10, width of `haddr`/`vaddr`; H_TOTAL and V_TOTAL must each be ≤ 2^ADDR_W
- `RGB_LAT`, 0, renderer latency in pix_ce steps, legal 0..4
- `FRAME_W`, 8, frame counter width

Ports:
- `clk` in 1: system clock
- `sys_rst` in 1: synchronous, active-high reset
- `pix_ce` in 1: pixel clock enable; one ce step = one clk with pix_ce=1
- `rgb_in` in 6: renderer colour {r[1:0], g[1:0], b[1:0]} for the coordinate issued RGB_LAT ce steps earlier
- `haddr` out ADDR_W: current horizontal count
- `vaddr` out ADDR_W: current vertical count
- `display_on` out 1: haddr < H_ACTIVE and vaddr < V_ACTIVE (undelayed)
- `line_start` out 1: strobe, pix_ce & (haddr == 0)
- `frame_start` out 1: strobe, pix_ce & (haddr == 0) & (vaddr == 0)
- `frame_cnt` out FRAME_W: completed frames, modulo 2^FRAME_W
- `VGA_rgb` out 8: {hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]}

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- On each ce step: haddr increments; at H_TOTAL-1 it wraps to 0 and vaddr increments; vaddr wraps to 0 at V_TOTAL-1. frame_cnt increments on the step where both wrap, wrapping modulo 2^FRAME_W.
- No ce step: every register holds.
- hsync active for haddr in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync active for vaddr in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); driven at the level selected by *_POL, the inverse otherwise.
- hsync, vsync and display_on are decoded from the counters and passed through an RGB_LAT-deep delay line that shifts on ce steps only; with RGB_LAT=0 there is no delay.
- The output register loads on each ce step: delayed syncs, and colour = rgb_in if delayed display_on is high, else 0.
- sys_rst takes priority over pix_ce.

## Timing
- Reset values: haddr=0, vaddr=0, display_on=1 (counters at 0,0), frame_cnt=0, delay line holds inactive sync and display_on=0, VGA_rgb = inactive syncs with colour 0 (8'h88 at default polarity). line_start/frame_start equal pix_ce after reset.
- The coordinate present on haddr/vaddr during ce step k appears on VGA_rgb after the clk edge of ce step k+RGB_LAT.
- The renderer must present rgb_in for a coordinate exactly RGB_LAT ce steps after issuing it.
- A mid-frame reset clears counters, delay line and output register at the next edge. No stale colour or sync is emitted afterwards.
- Strobes are combinational from registered state and pix_ce, so they are high for one clk per event.

## Structure
- Package `vga_timing_pkg`: default 640x480@60 constants (porches, sync widths, totals) and the PMOD bit-order indices.
- Sub-module `vga_delay_line`: parametrised width/depth shift register with enable, depth 0 = wire; one instance carries {hsync, vsync, display_on}.

## Test plan
- Hold sys_rst 5 clk with pix_ce=1 → haddr=0, vaddr=0, frame_cnt=0, VGA_rgb=8'h88; release → haddr=1 after the first ce step.
- Defaults, pix_ce=1 constant, RGB_LAT=0 → VGA_rgb[7] low for exactly 96 of every 800 clk, first low on the edge when haddr advances past 656. line_start pulses every 800 clk.
- Defaults → VGA_rgb[3] low for exactly 1600 clk per 420000-clk frame, beginning with vaddr=490. frame_cnt 255→0 on the 256th frame.
- pix_ce alternating 1/0 → all outputs frozen on ce=0 clks, line period 1600 clk, hsync width 192 clk.
- RGB_LAT=2, rgb_in=6'h3F → colour bits all 1 only for active pixels, 0 throughout blanking. First 1s appear on the edge of the ce step two steps after (0,0) is issued.
- Assert sys_rst at haddr=300, vaddr=200 with rgb_in=6'h3F → next edge: all reset values. The following two ce steps emit colour 0.
